// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the programmable-threshold synchronous FIFO.
//   count_width()   : width of the fill-level / pointer type for a given depth
//   PROG_SEL_AE/AF  : prog_sel_i encodings selecting which threshold to load
//   sat_threshold() : clamps a requested threshold so the AE and AF regions
//                     can never overlap
package syn_fifo_pkg;

    localparam logic PROG_SEL_AE = 1'b0;
    localparam logic PROG_SEL_AF = 1'b1;

    // One extra bit over the index width, so that 0..DEPTH is representable
    // and the pointer MSB can serve as the wrap bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Largest offset that keeps count <= X_ae+1 and count >= DEPTH-X_af+1 disjoint.
    function automatic int unsigned sat_threshold(input int unsigned value,
                                                  input int unsigned depth);
        int unsigned limit;
        limit = depth / 2 - 1;
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/syn_fifo_prog_flags.sv
// Status-flag decode for syn_fifo_prog. Purely combinational from the
// registered fill level and registered thresholds, so no flag has a path
// from the request inputs.
//   count_i        : current fill level, 0..DEPTH
//   x_ae_i, x_af_i : almost-empty / almost-full offsets
//   full_o, empty_o, almost_empty_o, almost_full_o, af_ae_o : decoded flags
module syn_fifo_prog_flags
    import syn_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic [CW-1:0] count_i,
    input  logic [CW-1:0] x_ae_i,
    input  logic [CW-1:0] x_af_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_empty_o,
    output logic          almost_full_o,
    output logic          af_ae_o
);

    // One bit wider so X_ae+1 and count+X_af cannot wrap.
    logic [CW:0] ae_limit;
    logic [CW:0] af_sum;

    // count >= DEPTH-X_af+1 is rewritten as count+X_af >= DEPTH+1 to avoid
    // an unsigned subtraction.
    assign ae_limit = {1'b0, x_ae_i} + (CW+1)'(1);
    assign af_sum   = {1'b0, count_i} + {1'b0, x_af_i};

    assign full_o         = (count_i == CW'(DEPTH));
    assign empty_o        = (count_i == '0);
    assign almost_empty_o = ({1'b0, count_i} <= ae_limit);
    assign almost_full_o  = (af_sum >= (CW+1)'(DEPTH + 1));
    assign af_ae_o        = almost_empty_o | almost_full_o;

endmodule

// File: rtl/syn_fifo_prog.sv
// Single-clock FIFO with programmable almost-empty / almost-full offsets,
// fill-level output and sticky error flags.
//   clk_i, rst_i        : clock (rising edge), asynchronous active-high reset
//   wr_en_i, wr_data_i  : write request and data
//   rd_en_i             : read request
//   rd_data_o           : registered read data, valid when rd_valid_o pulses
//   prog_en_i/sel/data  : threshold load (only while empty and not writing)
//   err_clr_i           : clears overflow_o, underflow_o, prog_err_o
//   full_o .. af_ae_o   : status flags decoded from registered state
//   count_o             : fill level 0..DEPTH
module syn_fifo_prog
    import syn_fifo_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int DATA_WIDTH = 8,
    parameter  int DEF_AE     = 5,
    parameter  int DEF_AF     = 5,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = count_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  prog_en_i,
    input  logic                  prog_sel_i,
    input  logic [CW-1:0]         prog_data_i,
    input  logic                  err_clr_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
    output logic                  af_ae_o,
    output logic [CW-1:0]         count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  prog_err_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         x_ae;
    logic [CW-1:0]         x_af;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  prog_acc;
    logic [CW-1:0]         prog_value;

    // The wrap bit makes the modular pointer difference exactly the fill
    // level, including the full case where the indices are equal.
    assign count_o = wr_ptr - rd_ptr;

    assign rd_acc   = rd_en_i & ~empty_o;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign wr_acc   = wr_en_i & (~full_o | rd_acc);
    assign prog_acc = prog_en_i & empty_o & ~wr_acc;

    assign prog_value = CW'(sat_threshold(32'(prog_data_i), DEPTH));

    // NOTE: storage has no reset; only pointers define what is valid, and
    // leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            x_ae        <= CW'(DEF_AE);
            x_af        <= CW'(DEF_AF);
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            prog_err_o  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + CW'(1);
                rd_data_o <= mem[rd_ptr[AW-1:0]];
            end
            rd_valid_o <= rd_acc;

            if (prog_acc) begin
                if (prog_sel_i == PROG_SEL_AF) begin
                    x_af <= prog_value;
                end else begin
                    x_ae <= prog_value;
                end
            end

            // A new error wins over a same-cycle clear.
            overflow_o  <= (wr_en_i & ~wr_acc)     | (overflow_o  & ~err_clr_i);
            underflow_o <= (rd_en_i & ~rd_acc)     | (underflow_o & ~err_clr_i);
            prog_err_o  <= (prog_en_i & ~prog_acc) | (prog_err_o  & ~err_clr_i);
        end
    end

    syn_fifo_prog_flags #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_flags (
        .count_i        (count_o),
        .x_ae_i         (x_ae),
        .x_af_i         (x_af),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_empty_o (almost_empty_o),
        .almost_full_o  (almost_full_o),
        .af_ae_o        (af_ae_o)
    );

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Self-checking bench for syn_fifo_prog: directed scenarios followed by a
// randomized phase, checked against a queue-based reference model. Read
// data is compared by a separate monitor against a scoreboard queue.
module tb_syn_fifo_prog;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = 5;
    localparam int DEF_X = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wr_en_i;
    logic [DW-1:0] wr_data_i;
    logic          rd_en_i;
    logic [DW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          prog_en_i;
    logic          prog_sel_i;
    logic [CW-1:0] prog_data_i;
    logic          err_clr_i;
    logic          full_o, empty_o, almost_empty_o, almost_full_o, af_ae_o;
    logic [CW-1:0] count_o;
    logic          overflow_o, underflow_o, prog_err_o;

    syn_fifo_prog #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .DEF_AE     (DEF_X),
        .DEF_AF     (DEF_X)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wr_data_i      (wr_data_i),
        .rd_en_i        (rd_en_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .prog_en_i      (prog_en_i),
        .prog_sel_i     (prog_sel_i),
        .prog_data_i    (prog_data_i),
        .err_clr_i      (err_clr_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_empty_o (almost_empty_o),
        .almost_full_o  (almost_full_o),
        .af_ae_o        (af_ae_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .prog_err_o     (prog_err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, thresholds, sticky errors, valid pulse.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_xae, m_xaf;
    bit            m_ovf, m_udf, m_perr, m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_xae   = DEF_X;
        m_xaf   = DEF_X;
        m_ovf   = 0;
        m_udf   = 0;
        m_perr  = 0;
        m_valid = 0;
    endtask

    task automatic compare_all();
        int n;
        bit e_ae, e_af;
        n    = m_q.size();
        e_ae = (n <= m_xae + 1);
        e_af = (n >= DEPTH - m_xaf + 1);
        check("count", 32'(count_o), n);
        check("flags{full,empty,ae,af,afae}",
              {full_o, empty_o, almost_empty_o, almost_full_o, af_ae_o},
              {n == DEPTH, n == 0, e_ae, e_af, e_ae | e_af});
        check("errors{ovf,udf,perr}", {overflow_o, underflow_o, prog_err_o},
              {m_ovf, m_udf, m_perr});
        check("rd_valid", 32'(rd_valid_o), 32'(m_valid));
    endtask

    // One clock of stimulus; the model advances with the request, then all
    // outputs are compared just after the edge.
    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd,
                        input bit pe, input bit ps, input logic [CW-1:0] pd,
                        input bit clr);
        int n, v;
        bit rd_ok, wr_ok, prog_ok;
        wr_en_i     = wr;
        wr_data_i   = wd;
        rd_en_i     = rd;
        prog_en_i   = pe;
        prog_sel_i  = ps;
        prog_data_i = pd;
        err_clr_i   = clr;

        n       = m_q.size();
        rd_ok   = rd && (n > 0);
        wr_ok   = wr && ((n < DEPTH) || rd_ok);
        prog_ok = pe && (n == 0) && !wr_ok;
        m_ovf   = (wr && !wr_ok)   || (m_ovf  && !clr);
        m_udf   = (rd && !rd_ok)   || (m_udf  && !clr);
        m_perr  = (pe && !prog_ok) || (m_perr && !clr);
        m_valid = rd_ok;
        if (rd_ok) exp_q.push_back(m_q.pop_front());
        if (wr_ok) m_q.push_back(wd);
        if (prog_ok) begin
            v = (int'(pd) > DEPTH / 2 - 1) ? DEPTH / 2 - 1 : int'(pd);
            if (ps) m_xaf = v;
            else    m_xae = v;
        end

        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic wr_word(input logic [DW-1:0] d); step(1, d, 0, 0, 0, '0, 0); endtask
    task automatic rd_word();                       step(0, '0, 1, 0, 0, '0, 0); endtask
    task automatic rw_word(input logic [DW-1:0] d); step(1, d, 1, 0, 0, '0, 0); endtask
    task automatic idle();                          step(0, '0, 0, 0, 0, '0, 0); endtask
    task automatic err_clear();                     step(0, '0, 0, 0, 0, '0, 1); endtask
    task automatic prog(input bit sel, input logic [CW-1:0] val);
        step(0, '0, 0, 1, sel, val, 0);
    endtask

    task automatic drain();
        while (m_q.size() > 0) rd_word();
        idle();
    endtask

    // Read-data monitor, decoupled from stimulus.
    always @(negedge clk_i) begin
        logic [DW-1:0] d;
        if (!rst_i && rd_valid_o) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_data_o), 32'hFFFF_FFFF);
            end else begin
                d = exp_q.pop_front();
                check("rd_data", 32'(rd_data_o), 32'(d));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b1;
        wr_en_i     = 1'b0;
        wr_data_i   = '0;
        rd_en_i     = 1'b0;
        prog_en_i   = 1'b0;
        prog_sel_i  = 1'b0;
        prog_data_i = '0;
        err_clr_i   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        compare_all();
        check("rst_rd_data", 32'(rd_data_o), 0);
        rst_i = 1'b0;

        // 1: fill, overflow, ordered drain.
        for (int i = 0; i < DEPTH; i++) wr_word(DW'(i));
        wr_word(8'hEE);
        for (int i = 0; i < DEPTH; i++) rd_word();
        idle();
        err_clear();

        // 2: AE/AF boundaries one word at a time (X=5).
        for (int i = 0; i < 12; i++) wr_word(8'h40 + DW'(i));
        drain();

        // 3: pointer wrap.
        for (int i = 0; i < 10; i++) wr_word(8'h80 + DW'(i));
        for (int i = 0; i < 10; i++) rd_word();
        for (int i = 0; i < 12; i++) wr_word(8'hA0 + DW'(i));
        drain();

        // 4: simultaneous read/write when full, then when empty.
        for (int i = 0; i < DEPTH; i++) wr_word(8'hC0 + DW'(i));
        rw_word(8'h5A);
        rw_word(8'h5B);
        drain();
        rw_word(8'h77);
        err_clear();
        drain();

        // 5: threshold programming with saturation and rejected loads.
        prog(0, 5'd3);
        prog(1, 5'd9);
        for (int i = 0; i < 10; i++) wr_word(8'h10 + DW'(i));
        for (int i = 0; i < 8; i++) rd_word();
        prog(0, 5'd1);
        err_clear();

        // 6: asynchronous reset mid-clock with count=9.
        for (int i = 0; i < 7; i++) wr_word(8'h20 + DW'(i));
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_rd_data", 32'(rd_data_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) wr_word(8'h30 + DW'(i));
        drain();
        step(1, 8'h99, 0, 1, 0, 5'd2, 0);
        err_clear();
        drain();

        // Randomized phase: write-heavy then read-heavy traffic.
        for (int i = 0; i < 1500; i++) begin
            int  pw;
            bit  wr, rd, pe, clr;
            pw  = (i < 750) ? 65 : 35;
            wr  = ($urandom_range(0, 99) < pw);
            rd  = ($urandom_range(0, 99) < 100 - pw);
            pe  = ($urandom_range(0, 99) < 4);
            clr = ($urandom_range(0, 99) < 5);
            step(wr, DW'($urandom), rd, pe, 1'($urandom), CW'($urandom), clr);
        end
        drain();
        idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/syn_fifo_prog.md
Name: syn_fifo_prog

Overview:
Parametrised single-clock FIFO, successor to syn_fifo. Generalised in DATA_WIDTH and DEPTH, with:
- independently programmable almost-empty and almost-full offsets (the legacy combined af_ae_o is kept);
- a fill-level output;
- sticky overflow and underflow error flags.

It buffers data between producer and consumer blocks within one clock domain.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4.
DATA_WIDTH, 8, word width in bits.
DEF_AE, 5, almost-empty offset (X_ae) after reset.
DEF_AF, 5, almost-full offset (X_af) after reset.
Derived: AW = $clog2(DEPTH), CW = AW+1.

Ports:
clk_i  in  1  system clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
wr_en_i  in  1  write request.
wr_data_i  in  DATA_WIDTH  write data.
rd_en_i  in  1  read request.
rd_data_o  out  DATA_WIDTH  read data, registered.
rd_valid_o  out  1  one-cycle pulse: rd_data_o updated.
prog_en_i  in  1  threshold load strobe.
prog_sel_i  in  1  0 = load X_ae, 1 = load X_af.
prog_data_i  in  CW  threshold value.
err_clr_i  in  1  clears sticky errors.
full_o  out  1  count == DEPTH.
empty_o  out  1  count == 0.
almost_empty_o  out  1  count <= X_ae+1.
almost_full_o  out  1  count >= DEPTH-X_af+1.
af_ae_o  out  1  almost_empty_o | almost_full_o.
count_o  out  CW  current fill level, 0..DEPTH.
overflow_o  out  1  sticky: write rejected because full.
underflow_o  out  1  sticky: read rejected because empty.
prog_err_o  out  1  sticky: load rejected because not empty.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: pointers=0, count=0, rd_data_o=0, rd_valid_o=0. empty_o=1, almost_empty_o=1, af_ae_o=1. full_o=0, almost_full_o=0. All sticky errors=0. X_ae=DEF_AE, X_af=DEF_AF.
- Reset asserted mid-operation: all of the above take effect immediately; stored data is discarded.
- Pointers: wr_ptr and rd_ptr are CW bits wide. The MSB is the wrap bit; the memory is indexed by ptr[AW-1:0]. Wrap from DEPTH-1 to 0 is natural binary rollover.
- Write acceptance: wr_acc = wr_en_i & (~full_o | rd_acc).
  - Accepted write: mem[wr_ptr] written and wr_ptr incremented at the edge.
- Read acceptance: rd_acc = rd_en_i & ~empty_o.
  - Accepted read: rd_data_o <= mem[rd_ptr], rd_ptr incremented, rd_valid_o=1 in the following cycle.
  - Read latency: 1 clock.
- Simultaneous read and write:
  - Full: both are accepted; count is unchanged.
  - Empty: the write is accepted, the read is rejected and sets underflow_o. There is no write-through.
- Errors:
  - A write with full and no accepted read is dropped and sets overflow_o.
  - Sticky flags are held until err_clr_i. If err_clr_i and a new error occur in the same cycle, the flag sets.
- count: count <= count + wr_acc - rd_acc. count == wr_ptr - rd_ptr (mod 2^CW) at all times.
- Flag timing: all flags decode registered state only, with no combinational path from wr_en_i or rd_en_i. Flags change on the same edge as count.
- Threshold programming: accepted only when empty_o=1 and no write is accepted in that cycle. Otherwise the load is ignored and prog_err_o sets.
  - Loaded values are saturated to DEPTH/2-1 so the AE and AF regions never overlap.
  - A new threshold affects flags from the next cycle.

Decomposition:
- Package syn_fifo_pkg holds:
  - the function for the CW-width count type, parametrised on DEPTH;
  - localparams PROG_SEL_AE=0 and PROG_SEL_AF=1;
  - a saturate function for thresholds.
- One sub-module, syn_fifo_prog_flags: takes count, X_ae and X_af; produces the registered-state flag decode. Pointers, memory and error logic stay in the top module.

Test Plan:
All scenarios use DEPTH=16, DATA_WIDTH=8, X=5.
1. Reset, then 16 writes of 0x00..0x0F:
   - count_o=16, full_o=1.
   - A 17th write is dropped and overflow_o=1.
   - 16 reads return 0x00..0x0F in order, each 1 cycle after its rd_en_i, then empty_o=1.
2. AE/AF boundaries with X=5, filling one word at a time:
   - count 6: af_ae_o=1.
   - count 7: af_ae_o=0.
   - count 11: af_ae_o=0.
   - count 12: af_ae_o=1, almost_full_o=1.
3. Wrap-around: write 10, read 10, write 12.
   - count_o=12; data read back intact across the pointer wrap.
   - empty_o=0 while pointer indices are unequal.
4. Simultaneous read and write:
   - When full: both accepted, count stays 16, no overflow_o.
   - When empty: write accepted, underflow_o=1, count_o=1.
5. Programming:
   - With FIFO empty, load X_ae=3 and X_af=9: X_af saturates to 7. Then count 4 gives almost_empty_o=1, count 5 gives 0, count 10 gives almost_full_o=1.
   - A load attempted with count=2 is ignored and sets prog_err_o.
   - err_clr_i clears all sticky flags.
6. Assert rst_i asynchronously, mid-clock, while count=9:
   - Outputs return immediately to reset values.
   - Thresholds revert to 5.
